// File: rtl/pipelined_data_memory.sv
// pipelined_data_memory: byte-addressable MEM-stage data memory with a fixed access latency
// and a req/done handshake; misaligned or out-of-range accesses are rejected without writing.
module pipelined_data_memory #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [7:0]  memory_o
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, stateNext;
  logic [CW-1:0] count;
  logic weQ, unsQ;
  logic [1:0] sizeQ;
  logic [31:0] addrQ, wdataQ;
  logic [7:0] mem [DEPTH_BYTES];
  logic access, accErr;
  logic [32:0] lastByte;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [7:0] b0, b1, b2, b3;
  logic [31:0] readVal;
  always_comb begin
    stateNext = state == IDLE ? (req_i ? BUSY : IDLE)
              : state == BUSY ? (count == '0 ? DONE : BUSY) : IDLE;
  end
  assign access = state == BUSY && count == '0;
  assign busy_o = state != IDLE;
  assign done_o = state == DONE;
  // last byte touched, computed on 33 bits so high addresses cannot wrap into range
  assign lastByte = {1'b0, addrQ} + (sizeQ == 2'b10 ? 33'd3 : sizeQ == 2'b01 ? 33'd1 : 33'd0);
  assign accErr = sizeQ == 2'b11 || (sizeQ == 2'b01 && addrQ[0]) ||
                  (sizeQ == 2'b10 && addrQ[1:0] != 2'b00) || lastByte >= 33'(DEPTH_BYTES);
  assign a0 = addrQ[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];
  assign readVal = sizeQ == 2'b00 ? {{24{~unsQ & b0[7]}}, b0}
                 : sizeQ == 2'b01 ? {{16{~unsQ & b1[7]}}, b1, b0} : {b3, b2, b1, b0};
  assign memory_o = mem[0];
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      count   <= '0;
      weQ     <= 1'b0;
      unsQ    <= 1'b0;
      sizeQ   <= 2'b00;
      addrQ   <= '0;
      wdataQ  <= '0;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && req_i) begin
        count  <= CW'(LATENCY - 1);
        weQ    <= we_i;
        unsQ   <= unsigned_i;
        sizeQ  <= size_i;
        addrQ  <= addr_i;
        wdataQ <= wdata_i;
      end else if (state == BUSY && count != '0) count <= count - CW'(1);
      if (access) begin
        err_o <= accErr;
        if (accErr) rdata_o <= '0;
        else if (!weQ) rdata_o <= readVal;
      end
    end
  end
  // array is deliberately unreset; access is low whenever reset holds the FSM in IDLE
  always_ff @(posedge clk_i) begin
    if (access && weQ && !accErr) begin
      mem[a0] <= wdataQ[7:0];
      if (sizeQ != 2'b00) mem[a1] <= wdataQ[15:8];
      if (sizeQ == 2'b10) begin
        mem[a2] <= wdataQ[23:16];
        mem[a3] <= wdataQ[31:24];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_data_memory.sv
// tb_pipelined_data_memory: directed and random accesses checked against a byte-array model.
module tb_pipelined_data_memory;
  localparam int DEPTH = 1024;
  localparam int LAT = 2;
  logic clk = 0, rstN = 0, req = 0, we = 0, uns = 0;
  logic [1:0] size = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic busy, done, err;
  logic [31:0] rdata;
  logic [7:0] memOut;
  int checks = 0, failures = 0;
  logic [7:0] refMem [DEPTH];
  logic [31:0] expRdata = 0;
  logic expErr = 0;

  pipelined_data_memory #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rstN), .req_i(req), .we_i(we), .size_i(size), .unsigned_i(uns),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done), .err_o(err),
    .rdata_o(rdata), .memory_o(memOut));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nBytes(input logic [1:0] s);
    return s == 2'd0 ? 1 : s == 2'd1 ? 2 : s == 2'd2 ? 4 : 0;
  endfunction

  function automatic bit modelErr(input logic [1:0] s, input logic [31:0] a);
    int n = nBytes(s);
    if (n == 0) return 1;
    if (longint'(a) % n != 0) return 1;
    return longint'(a) + n - 1 >= DEPTH;
  endfunction

  function automatic logic [31:0] modelRead(input logic [1:0] s, input logic u, input logic [31:0] a);
    longint v = 0;
    int n = nBytes(s);
    for (int i = 0; i < n; i++) v += longint'(refMem[int'(a) + i]) << (8 * i);
    if (!u && v[8*n-1]) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic applyModel(input logic w, input logic [1:0] s, input logic u,
                            input logic [31:0] a, input logic [31:0] d);
    expErr = modelErr(s, a);
    if (expErr) expRdata = 0;
    else if (w) for (int i = 0; i < nBytes(s); i++) refMem[int'(a) + i] = d[8*i +: 8];
    else expRdata = modelRead(s, u, a);
  endtask

  task automatic access(input logic w, input logic [1:0] s, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1; we = w; size = s; uns = u; addr = a; wdata = d;
    @(posedge clk); #1;
    check("acc_busy", {31'b0, busy}, 1);
    check("acc_done", {31'b0, done}, 0);
    @(negedge clk);
    req = 0; we = ~w; size = ~s; addr = ~a; wdata = ~d;
    @(posedge clk); #1;
    check("mid_done", {31'b0, done}, 0);
    check("mid_rdata", rdata, expRdata);
    applyModel(w, s, u, a, d);
    @(posedge clk); #1;
    check("cmp_done", {31'b0, done}, 1);
    check("cmp_busy", {31'b0, busy}, 1);
    check("cmp_err", {31'b0, err}, {31'b0, expErr});
    check("cmp_rdata", rdata, expRdata);
    check("cmp_mem0", {24'b0, memOut}, {24'b0, refMem[0]});
    @(posedge clk); #1;
    check("end_done", {31'b0, done}, 0);
    check("end_busy", {31'b0, busy}, 0);
    check("end_err", {31'b0, err}, {31'b0, expErr});
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1;
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk); rstN = 1;
    for (int i = 0; i < DEPTH; i += 4) access(1, 2'd2, 0, i, $urandom);
    // word write/read and byte sign extension
    access(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    access(0, 2'd2, 0, 32'h10, 0);
    check("word10", rdata, 32'hDEADBEEF);
    access(0, 2'd0, 0, 32'h13, 0);
    check("byte13", rdata, 32'hFFFFFFDE);
    access(1, 2'd0, 0, 32'h05, 32'h80);
    access(1, 2'd0, 0, 32'h04, 32'h34);
    access(0, 2'd0, 0, 32'h05, 0);
    check("byte5s", rdata, 32'hFFFFFF80);
    access(0, 2'd0, 1, 32'h05, 0);
    check("byte5u", rdata, 32'h00000080);
    access(0, 2'd1, 0, 32'h04, 0);
    check("half4s", rdata, 32'hFFFF8034);
    // rejected accesses
    access(1, 2'd1, 0, 32'h21, 32'hFFFF);
    check("err_h21", {31'b0, err}, 1);
    access(0, 2'd2, 0, 32'h02, 0);
    check("err_w02", {31'b0, err}, 1);
    check("err_w02_rd", rdata, 0);
    access(0, 2'd3, 0, 32'h08, 0);
    check("err_sz3", {31'b0, err}, 1);
    access(1, 2'd2, 0, DEPTH - 2, 32'hA5A5A5A5);
    check("err_top", {31'b0, err}, 1);
    access(1, 2'd2, 0, 32'hFFFFFFFC, 32'h11111111);
    check("err_wrap", {31'b0, err}, 1);
    // reset while the write is pending
    access(0, 2'd2, 0, 32'h10, 0);
    @(negedge clk);
    req = 1; we = 1; size = 2'd2; uns = 0; addr = 0; wdata = 32'h12345678;
    @(posedge clk); #1;
    @(negedge clk); req = 0;
    @(posedge clk); #1;
    rstN = 0; #1;
    check("rstm_busy", {31'b0, busy}, 0);
    check("rstm_done", {31'b0, done}, 0);
    check("rstm_rdata", rdata, 0);
    check("rstm_err", {31'b0, err}, 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rstN = 1;
    expRdata = 0; expErr = 0;
    check("rstm_mem0", {24'b0, memOut}, {24'b0, refMem[0]});
    access(0, 2'd2, 0, 32'h0, 0);
    // back-to-back with req held high; inputs changed while busy
    @(negedge clk);
    req = 1; we = 1; size = 2'd2; uns = 0; addr = 32'h40; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    check("b2b_acc1", {31'b0, busy}, 1);
    @(negedge clk);
    we = 0;
    @(posedge clk);
    applyModel(1, 2'd2, 0, 32'h40, 32'hCAFEF00D);
    @(posedge clk); #1;
    check("b2b_done1", {31'b0, done}, 1);
    @(posedge clk); #1;
    check("b2b_idle", {31'b0, busy}, 0);
    check("b2b_dfall", {31'b0, done}, 0);
    @(posedge clk); #1;
    check("b2b_acc2", {31'b0, busy}, 1);
    check("b2b_nod", {31'b0, done}, 0);
    @(negedge clk); req = 0;
    @(posedge clk);
    applyModel(0, 2'd2, 0, 32'h40, 0);
    @(posedge clk); #1;
    check("b2b_done2", {31'b0, done}, 1);
    check("b2b_rd", rdata, 32'hCAFEF00D);
    @(posedge clk); #1;
    check("b2b_end", {31'b0, done}, 0);
    // debug view of byte 0
    access(1, 2'd0, 0, 32'h0, 32'h5A);
    check("dbg_5a", {24'b0, memOut}, 32'h5A);
    access(1, 2'd0, 0, 32'h1, 32'hC3);
    check("dbg_keep", {24'b0, memOut}, 32'h5A);
    // random traffic, then full readback
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = ($urandom % 8 == 0) ? $urandom : $urandom_range(0, DEPTH + 4);
      access($urandom % 2, 2'($urandom % 4), $urandom % 2, a, $urandom);
    end
    for (int i = 0; i < DEPTH; i += 4) access(0, 2'd2, 0, i, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
